// File: rtl/spi_top.sv
// SPI-slave LED controller. 24-bit mode-0 frames set or read a 7-bit brightness
// per channel, and each channel drives its LED with a 100-step PWM.
module spi_top #(
    parameter int         NUM_LEDS         = 8,
    parameter int         FRAME_WIDTH      = 24,
    parameter int         BRIGHTNESS_WIDTH = 8,
    parameter int         MAX_BRIGHTNESS   = 100,
    parameter int         PWM_PRESCALE     = 1250,
    parameter logic [7:0] CMD_NOP          = 8'h00,
    parameter logic [7:0] CMD_LED_SET      = 8'h01,
    parameter logic [7:0] CMD_LED_READ     = 8'h02
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic miso,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic led4,
    output logic led5,
    output logic led6,
    output logic led7,
    output logic led8
);
    localparam int CNT_W  = $clog2(FRAME_WIDTH + 1);
    localparam int ADDR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int PRE_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int LVL_W  = BRIGHTNESS_WIDTH - 1;

    localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(FRAME_WIDTH);
    localparam logic [CNT_W-1:0] HDR_BITS   = CNT_W'(FRAME_WIDTH - 8);
    localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(FRAME_WIDTH - 9);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [7:0]       NUM_LEDS_B = 8'(NUM_LEDS);
    localparam logic [LVL_W-1:0] MAX_LVL    = LVL_W'(MAX_BRIGHTNESS);
    localparam logic [LVL_W-1:0] TICK_LAST  = LVL_W'(MAX_BRIGHTNESS - 1);
    localparam logic [LVL_W-1:0] TICK_ONE   = LVL_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(PWM_PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1);

    logic [2:0]                  sclk_sync_r;
    logic [2:0]                  cs_sync_r;
    logic [1:0]                  mosi_sync_r;
    logic                        sclk_rise_s;
    logic                        sclk_fall_s;
    logic                        cs_rise_s;
    logic                        cs_fall_s;
    logic                        cs_low_s;
    logic [FRAME_WIDTH-1:0]      rx_r;
    logic [FRAME_WIDTH-1:0]      rx_shift_s;
    logic [CNT_W-1:0]            cnt_r;
    logic [BRIGHTNESS_WIDTH-1:0] tx_r;
    logic [BRIGHTNESS_WIDTH-1:0] rd_data_s;
    logic [7:0]                  hdr_cmd_s;
    logic [7:0]                  hdr_addr_s;
    logic                        commit_s;
    logic [LVL_W-1:0]            commit_lvl_s;
    logic [LVL_W-1:0]            led_brightness [0:NUM_LEDS-1];
    logic [PRE_W-1:0]            presc_r;
    logic [LVL_W-1:0]            tick_r;
    logic [NUM_LEDS-1:0]         led_r;

    function automatic logic [LVL_W-1:0] clamp_level(input logic [LVL_W-1:0] raw);
        if (raw > MAX_LVL) begin
            clamp_level = MAX_LVL;
        end else begin
            clamp_level = raw;
        end
    endfunction

    // Bring the SPI pins into the sysclk domain; bit 2 holds the previous sample for edge detection.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 3'b111;
            mosi_sync_r <= 2'b00;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], sclk};
            cs_sync_r   <= {cs_sync_r[1:0], cs};
            mosi_sync_r <= {mosi_sync_r[0], mosi};
        end
    end

    assign sclk_rise_s =  sclk_sync_r[1] & ~sclk_sync_r[2];
    assign sclk_fall_s = ~sclk_sync_r[1] &  sclk_sync_r[2];
    assign cs_rise_s   =  cs_sync_r[1]   & ~cs_sync_r[2];
    assign cs_fall_s   = ~cs_sync_r[1]   &  cs_sync_r[2];
    assign cs_low_s    = ~cs_sync_r[1];

    // Decode the header as it completes so a read response is ready before the payload phase.
    always_comb begin
        rx_shift_s = {rx_r[FRAME_WIDTH-2:0], mosi_sync_r[1]};
        hdr_cmd_s  = rx_shift_s[15:8];
        hdr_addr_s = rx_shift_s[7:0];
        rd_data_s  = {BRIGHTNESS_WIDTH{1'b0}};
        if (hdr_cmd_s == CMD_LED_READ && hdr_addr_s < NUM_LEDS_B) begin
            rd_data_s = {1'b0, led_brightness[hdr_addr_s[ADDR_W-1:0]]};
        end else begin
            rd_data_s = {BRIGHTNESS_WIDTH{1'b0}};
        end
    end

    // Frame receive and read-response shifting. The falling edge right after the header is
    // skipped so the master's first payload sample sees the response MSB.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_r  <= {FRAME_WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            tx_r  <= {BRIGHTNESS_WIDTH{1'b0}};
        end else if (cs_fall_s) begin
            rx_r  <= {FRAME_WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            tx_r  <= {BRIGHTNESS_WIDTH{1'b0}};
        end else if (cs_rise_s) begin
            tx_r <= {BRIGHTNESS_WIDTH{1'b0}};
        end else if (cs_low_s && sclk_rise_s && cnt_r < FRAME_BITS) begin
            rx_r  <= rx_shift_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == HDR_LAST) begin
                tx_r <= rd_data_s;
            end
        end else if (cs_low_s && sclk_fall_s && cnt_r > HDR_BITS) begin
            tx_r <= {tx_r[BRIGHTNESS_WIDTH-2:0], 1'b0};
        end
    end

    // Commit decision for a completed frame.
    always_comb begin
        commit_s     = 1'b0;
        commit_lvl_s = clamp_level(rx_r[7:1]);
        if (cnt_r == FRAME_BITS && rx_r[15:8] < NUM_LEDS_B) begin
            case (rx_r[23:16])
                CMD_LED_SET:  commit_s = 1'b1;
                CMD_NOP:      commit_s = 1'b0;
                CMD_LED_READ: commit_s = 1'b0;
                default:      commit_s = 1'b0;
            endcase
        end else begin
            commit_s = 1'b0;
        end
    end

    // Brightness table, written only when a complete SET frame closes.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                led_brightness[i] <= {LVL_W{1'b0}};
            end
        end else if (cs_rise_s && commit_s) begin
            led_brightness[rx_r[ADDR_W+7:8]] <= commit_lvl_s;
        end
    end

    // PWM timebase: prescaler feeding a 0..MAX_BRIGHTNESS-1 tick counter.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PRE_W{1'b0}};
            tick_r  <= {LVL_W{1'b0}};
        end else if (presc_r == PRE_LAST) begin
            presc_r <= {PRE_W{1'b0}};
            if (tick_r == TICK_LAST) begin
                tick_r <= {LVL_W{1'b0}};
            end else begin
                tick_r <= tick_r + TICK_ONE;
            end
        end else begin
            presc_r <= presc_r + PRE_ONE;
        end
    end

    // Registered PWM compare per channel.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= {NUM_LEDS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                led_r[i] <= (tick_r < led_brightness[i]);
            end
        end
    end

    assign miso = tx_r[BRIGHTNESS_WIDTH-1];
    assign led1 = led_r[0];
    assign led2 = led_r[1];
    assign led3 = led_r[2];
    assign led4 = led_r[3];
    assign led5 = led_r[4];
    assign led6 = led_r[5];
    assign led7 = led_r[6];
    assign led8 = led_r[7];

endmodule

// File: tb/tb_spi_top.sv
// Bench for spi_top: SPI master at sysclk/8 with a queue scoreboard and a
// brightness-table reference model.
module tb_spi_top;
    logic sysclk = 1'b0;
    logic rst_n, sclk, cs, mosi, miso;
    logic led1, led2, led3, led4, led5, led6, led7, led8;
    logic [7:0] leds;

    always #5 sysclk = ~sysclk;

    spi_top #(.PWM_PRESCALE(1)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .led1(led1), .led2(led2), .led3(led3), .led4(led4),
        .led5(led5), .led6(led6), .led7(led7), .led8(led8)
    );

    assign leds = {led8, led7, led6, led5, led4, led3, led2, led1};

    typedef struct packed {
        logic        chk_rd;
        logic [7:0]  rd;
        logic [55:0] br;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         bright_m [8];
    logic       mon_en = 1'b0;
    int         mon_bits;
    logic [7:0] mon_rd;

    function automatic logic [55:0] pack_model();
        logic [55:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*7 +: 7] = 7'(bright_m[i]);
        return v;
    endfunction

    function automatic logic [55:0] pack_dut();
        logic [55:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*7 +: 7] = dut.led_brightness[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Master: records expectation from the model, then clocks the frame out.
    task automatic send(input logic [23:0] fr, input int nbits, input bit rst_abort);
        exp_t e;
        int   a;
        int   p;
        a = int'(fr[15:8]);
        e.chk_rd = (nbits == 24 && fr[23:16] == 8'h02 && !rst_abort);
        if (a < 8) e.rd = 8'(bright_m[a]);
        else       e.rd = 8'h00;
        if (rst_abort) begin
            for (int i = 0; i < 8; i++) bright_m[i] = 0;
        end else if (nbits == 24 && fr[23:16] == 8'h01 && a < 8) begin
            p = int'(fr[7:0]) / 2;
            bright_m[a] = (p > 100) ? 100 : p;
        end
        e.br = pack_model();
        exp_q.push_back(e);

        @(negedge sysclk);
        cs = 1'b0;
        repeat (4) @(negedge sysclk);
        for (int i = 0; i < nbits; i++) begin
            mosi = fr[23-i];
            repeat (4) @(negedge sysclk);
            sclk = 1'b1;
            repeat (4) @(negedge sysclk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge sysclk);
        if (rst_abort) begin
            rst_n = 1'b0;
            repeat (2) @(negedge sysclk);
        end
        cs = 1'b1;
        repeat (10) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic pwm_check();
        int cnt [8];
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge sysclk);
            for (int i = 0; i < 8; i++) cnt[i] += int'(leds[i]);
        end
        for (int i = 0; i < 8; i++) check($sformatf("pwm_duty_led%0d", i + 1), 64'(cnt[i]), 64'(bright_m[i]));
    endtask

    // Capture what a mode-0 master would sample on MISO during the payload byte.
    initial forever begin
        @(negedge cs);
        mon_bits = 0;
        mon_rd   = 8'h00;
    end

    initial forever begin
        @(posedge sclk);
        if (!cs) begin
            if (mon_bits >= 16 && mon_bits < 24) mon_rd = {mon_rd[6:0], miso};
            mon_bits++;
        end
    end

    // Scoreboard: each closed frame pops one expectation.
    initial forever begin
        exp_t e;
        @(posedge cs);
        if (mon_en) begin
            repeat (5) @(negedge sysclk);
            if (exp_q.size() == 0) begin
                check("frame_without_expectation", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("brightness_table", 64'(pack_dut()), 64'(e.br));
                if (e.chk_rd) check("read_response", 64'(mon_rd), 64'(e.rd));
            end
        end
    end

    initial begin
        logic [23:0] fr;
        int          sel;
        rst_n = 1'b0;
        cs    = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        for (int i = 0; i < 8; i++) bright_m[i] = 0;
        repeat (5) @(negedge sysclk);
        check("reset_brightness", 64'(pack_dut()), 64'(0));
        check("reset_leds", 64'(leds), 64'(0));
        check("reset_miso", 64'(miso), 64'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge sysclk);
        mon_en = 1'b1;

        send({8'h00, 8'hFF, 8'h00}, 24, 1'b0);
        check("leds_idle", 64'(leds), 64'(0));
        send({8'h01, 8'h00, 8'h50}, 24, 1'b0);
        send({8'h01, 8'h07, 8'h78}, 24, 1'b0);
        send({8'h01, 8'h10, 8'hFF}, 24, 1'b0);
        send({8'h01, 8'h03, 8'h00}, 24, 1'b0);
        send({8'h02, 8'h07, 8'h00}, 24, 1'b0);
        check("read7_const", 64'(mon_rd), 64'(8'h3C));
        send({8'h02, 8'h04, 8'hA5}, 24, 1'b0);
        send({8'h01, 8'h04, 8'hBE}, 24, 1'b0);
        send({8'h02, 8'h04, 8'h00}, 24, 1'b0);
        check("read4_const", 64'(mon_rd), 64'(8'h5F));
        send({8'h01, 8'h01, 8'hFE}, 24, 1'b0);
        check("clamp_const", 64'(dut.led_brightness[1]), 64'(100));
        pwm_check();

        // truncated frame (cs glitch mid-frame) followed by a clean restart
        send({8'h01, 8'h00, 8'h10}, 12, 1'b0);
        send({8'h01, 8'h02, 8'h20}, 24, 1'b0);

        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       fr[23:16] = 8'h00;
                1:       fr[23:16] = 8'h01;
                2:       fr[23:16] = 8'h02;
                default: fr[23:16] = 8'($urandom);
            endcase
            fr[15:8] = 8'($urandom_range(0, 11));
            fr[7:0]  = 8'($urandom);
            if ($urandom_range(0, 5) == 0) send(fr, int'($urandom_range(1, 23)), 1'b0);
            else                           send(fr, 24, 1'b0);
        end
        pwm_check();

        send({8'h01, 8'h05, 8'h40}, 12, 1'b1);
        pwm_check();

        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge sysclk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
